// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register file slice: architectural register
// indices that have a special meaning, default geometry, and a helper that
// decides whether a register number refers to real, writable storage.
// No ports (package).
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int REG_ZERO   = 0;   // hard-wired zero register
  localparam int REG_SP     = 29;  // stack pointer, reset to SP_INIT
  localparam int REG_RA     = 31;  // return address, reset to RA_INIT

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;

  // True when idx names a stored register: not r0, and inside the file even
  // when NREGS is not a power of two (upper encodings are treated like r0).
  function automatic logic idx_valid(input int idx, input int nregs);
    return (idx != REG_ZERO) && (idx < nregs);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundle of the register-file access signals shared between decode /
// write-back (master) and the register file (slave).
//   wr_en/wr_num/wr_data : NWR write-back ports, port i in slice i
//   rd_num/rd_data       : NRD read ports, port j in slice j
//   rd_busy              : per read port, source has a pending producer
//   iss_en/iss_num       : issue of an instruction that writes iss_num
//   pend                 : full scoreboard vector, bit 0 always 0
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int DATA_W = rf_pkg::DEF_DATA_W,
  parameter int NREGS  = rf_pkg::DEF_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_num;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NRD*AW-1:0]     rd_num;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_num;
  logic [NREGS-1:0]      pend;

  modport master (
    output wr_en, wr_num, wr_data, rd_num, iss_en, iss_num,
    input  rd_data, rd_busy, pend
  );

  modport slave (
    input  wr_en, wr_num, wr_data, rd_num, iss_en, iss_num,
    output rd_data, rd_busy, pend
  );

endinterface

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Pending-producer bit per architectural register.
//   clk, reset   : clock, synchronous active-high reset (clears all bits)
//   i_wr_en/num  : write-back ports; an enabled write retires its register
//   i_iss_en/num : issue; marks the destination as pending
//   i_rd_num     : read-port source numbers for the busy lookup
//   o_pend       : registered pending vector (bit 0 always 0)
//   o_rd_busy    : per read port, source still waiting on a producer
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_num,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_num,
  input  logic [NRD*AW-1:0] i_rd_num,
  output logic [NREGS-1:0]  o_pend,
  output logic [NRD-1:0]    o_rd_busy
);

  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_pend_nxt;
  logic [NRD-1:0]   w_busy;

  // Next pending vector: retire written registers, then mark the issued one.
  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int k = 1; k < NREGS; k++) begin
      for (int i = 0; i < NWR; i++) begin
        w_clr[k] = w_clr[k] | (i_wr_en[i] & (int'(i_wr_num[i*AW +: AW]) == k));
      end
      w_set[k] = i_iss_en & (int'(i_iss_num) == k);
    end
    w_pend_nxt    = (r_pend & ~w_clr) | w_set;
    w_pend_nxt[0] = 1'b0;
  end

  // Pending-bit register; reset discards every in-flight producer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Busy lookup per read port. With bypass, a write landing this cycle
  // already delivers the value, so the reader need not stall.
  always_comb begin
    logic [AW-1:0] v_num;
    logic          v_hit;
    w_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      v_num = i_rd_num[j*AW +: AW];
      v_hit = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        v_hit = v_hit | (i_wr_en[i] & (i_wr_num[i*AW +: AW] == v_num));
      end
      if (idx_valid(int'(v_num), NREGS)) begin
        w_busy[j] = r_pend[v_num] & ~((BYPASS != 0) & v_hit);
      end else begin
        w_busy[j] = 1'b0;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_rd_busy = w_busy;

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Multi-port register file with optional write-to-read bypass and a
// per-register scoreboard for RAW stall detection in decode.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; r29<-SP_INIT, r31<-RA_INIT, rest 0,
//           scoreboard cleared, writes/issues in that cycle ignored
//   rf    : regfile_sb_if slave modport (write ports, read ports, issue,
//           busy flags and pending vector)
// Reads are combinational; r0 is not stored and always reads zero.
// ---------------------------------------------------------------------------
module regfile_sb
  import rf_pkg::*;
#(
  parameter int              DATA_W  = DEF_DATA_W,
  parameter int              NREGS   = DEF_NREGS,
  parameter int              NRD     = 2,
  parameter int              NWR     = 1,
  parameter int              BYPASS  = 1,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  parameter logic [DATA_W-1:0] RA_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave rf
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]     r_regs [1:NREGS-1];
  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NREGS-1:0]      w_pend;
  logic [NRD-1:0]        w_rd_busy;

  // Storage update; ports are applied in index order so the highest
  // enabled port writing the same register is the one that sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < NREGS; k++) begin
        if (k == REG_SP) begin
          r_regs[k] <= SP_INIT;
        end else if (k == REG_RA) begin
          r_regs[k] <= RA_INIT;
        end else begin
          r_regs[k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (rf.wr_en[i] && idx_valid(int'(rf.wr_num[i*AW +: AW]), NREGS)) begin
          r_regs[rf.wr_num[i*AW +: AW]] <= rf.wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read mux: zero for r0, else stored value, overridden by a same-cycle
  // write when bypass is enabled (later ports override earlier ones).
  always_comb begin
    logic [AW-1:0]     v_num;
    logic [DATA_W-1:0] v_val;
    w_rd_data = '0;
    for (int j = 0; j < NRD; j++) begin
      v_num = rf.rd_num[j*AW +: AW];
      v_val = '0;
      if (idx_valid(int'(v_num), NREGS)) begin
        v_val = r_regs[v_num];
        for (int i = 0; i < NWR; i++) begin
          v_val = ((BYPASS != 0) && rf.wr_en[i] && (rf.wr_num[i*AW +: AW] == v_num))
                  ? rf.wr_data[i*DATA_W +: DATA_W] : v_val;
        end
      end else begin
        v_val = '0;
      end
      w_rd_data[j*DATA_W +: DATA_W] = v_val;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (rf.wr_en),
    .i_wr_num  (rf.wr_num),
    .i_iss_en  (rf.iss_en),
    .i_iss_num (rf.iss_num),
    .i_rd_num  (rf.rd_num),
    .o_pend    (w_pend),
    .o_rd_busy (w_rd_busy)
  );

  assign rf.rd_data = w_rd_data;
  assign rf.rd_busy = w_rd_busy;
  assign rf.pend    = w_pend;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Drives one stimulus stream into two register files (bypass on / off, two
// write ports) and checks both against an array-based model every cycle,
// plus literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
  import rf_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;
  localparam logic [31:0] SP = 32'h7FFF_FFFC;
  localparam logic [31:0] RA = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NWR-1:0]      s_wr_en;
  logic [NWR*AW-1:0]   s_wr_num;
  logic [NWR*DW-1:0]   s_wr_data;
  logic [NRD*AW-1:0]   s_rd_num;
  logic                s_iss_en;
  logic [AW-1:0]       s_iss_num;

  regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus_b ();
  regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) bus_n ();

  assign bus_b.wr_en   = s_wr_en;
  assign bus_b.wr_num  = s_wr_num;
  assign bus_b.wr_data = s_wr_data;
  assign bus_b.rd_num  = s_rd_num;
  assign bus_b.iss_en  = s_iss_en;
  assign bus_b.iss_num = s_iss_num;
  assign bus_n.wr_en   = s_wr_en;
  assign bus_n.wr_num  = s_wr_num;
  assign bus_n.wr_data = s_wr_data;
  assign bus_n.rd_num  = s_rd_num;
  assign bus_n.iss_en  = s_iss_en;
  assign bus_n.iss_num = s_iss_num;

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1),
               .SP_INIT(SP), .RA_INIT(RA)) dut_b (.clk(clk), .reset(reset), .rf(bus_b));
  regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(0),
               .SP_INIT(SP), .RA_INIT(RA)) dut_n (.clk(clk), .reset(reset), .rf(bus_n));

  // Behavioural model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  bit          m_valid = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] num);
    logic [31:0] v;
    if (num == 5'd0) return 32'd0;
    v = m_regs[num];
    if (byp)
      for (int p = 0; p < NWR; p++)
        if (s_wr_en[p] && s_wr_num[p*AW +: AW] == num) v = s_wr_data[p*DW +: DW];
    return v;
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] num);
    bit hit = 1'b0;
    if (num == 5'd0) return 1'b0;
    for (int p = 0; p < NWR; p++)
      if (s_wr_en[p] && s_wr_num[p*AW +: AW] == num) hit = 1'b1;
    return m_pend[num] && !(byp && hit);
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_regs[29] = SP;
      m_regs[31] = RA;
      m_pend     = 32'd0;
      m_valid    = 1'b1;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (s_wr_en[p] && s_wr_num[p*AW +: AW] != 5'd0) begin
          m_regs[s_wr_num[p*AW +: AW]] = s_wr_data[p*DW +: DW];
          m_pend[s_wr_num[p*AW +: AW]] = 1'b0;
        end
      end
      if (s_iss_en && s_iss_num != 5'd0) m_pend[s_iss_num] = 1'b1;
    end
  endtask

  // Every negedge: compare both DUTs with the model, then advance the model
  // with the inputs the next posedge will capture.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int j = 0; j < NRD; j++) begin
          logic [4:0] num;
          num = s_rd_num[j*AW +: AW];
          chk($sformatf("byp rd%0d r%0d", j, num), bus_b.rd_data[j*DW +: DW], exp_rd(1'b1, num));
          chk($sformatf("nobyp rd%0d r%0d", j, num), bus_n.rd_data[j*DW +: DW], exp_rd(1'b0, num));
          chk($sformatf("byp busy%0d r%0d", j, num), 32'(bus_b.rd_busy[j]), 32'(exp_busy(1'b1, num)));
          chk($sformatf("nobyp busy%0d r%0d", j, num), 32'(bus_n.rd_busy[j]), 32'(exp_busy(1'b0, num)));
        end
        chk("byp pend", bus_b.pend, m_pend);
        chk("nobyp pend", bus_n.pend, m_pend);
      end
      model_step();
    end
  end

  task automatic idle();
    s_wr_en   = '0;
    s_wr_num  = '0;
    s_wr_data = '0;
    s_iss_en  = 1'b0;
    s_iss_num = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input int num, input logic [31:0] d);
    s_wr_en[p]             = 1'b1;
    s_wr_num[p*AW +: AW]   = 5'(num);
    s_wr_data[p*DW +: DW]  = d;
  endtask

  task automatic rd(input int a, input int b);
    s_rd_num = {5'(b), 5'(a)};
  endtask

  task automatic iss(input int num);
    s_iss_en  = 1'b1;
    s_iss_num = 5'(num);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd(0, 0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset values
    rd(29, 31);
    @(negedge clk);
    chk("lit reset r29", bus_b.rd_data[31:0], 32'h7FFF_FFFC);
    chk("lit reset r31", bus_b.rd_data[63:32], 32'h0040_0000);
    chk("lit reset pend", bus_b.pend, 32'h0);
    chk("lit reset r29 nobyp", bus_n.rd_data[31:0], 32'h7FFF_FFFC);

    // Bypass vs no-bypass visibility
    cyc(); wr(0, 7, 32'hDEAD_BEEF); rd(5, 7);
    @(negedge clk);
    chk("lit byp r7 same cycle", bus_b.rd_data[63:32], 32'hDEAD_BEEF);
    chk("lit nobyp r7 same cycle", bus_n.rd_data[63:32], 32'h0);
    chk("lit r5 zero", bus_b.rd_data[31:0], 32'h0);
    cyc(); rd(7, 0);
    @(negedge clk);
    chk("lit nobyp r7 next cycle", bus_n.rd_data[31:0], 32'hDEAD_BEEF);
    chk("lit r0 read", bus_b.rd_data[63:32], 32'h0);

    // Two ports to the same register; write to r0
    cyc(); wr(0, 3, 32'd1); wr(1, 3, 32'd2); rd(3, 3);
    @(negedge clk);
    chk("lit byp r3 port1 wins", bus_b.rd_data[31:0], 32'd2);
    cyc(); wr(0, 0, 32'd5); rd(3, 0);
    @(negedge clk);
    chk("lit r3 stored port1", bus_n.rd_data[31:0], 32'd2);
    chk("lit byp r0 write ignored", bus_b.rd_data[63:32], 32'd0);
    cyc(); rd(0, 3);
    @(negedge clk);
    chk("lit r0 after write", bus_n.rd_data[31:0], 32'd0);
    chk("lit pend after r0 write", bus_b.pend, 32'h0);

    // Issue r9, later retire it
    cyc(); iss(9); rd(9, 9);
    @(negedge clk);
    chk("lit busy issue cycle", 32'(bus_b.rd_busy), 32'd0);
    cyc(); rd(9, 9);
    @(negedge clk);
    chk("lit byp busy after issue", 32'(bus_b.rd_busy), 32'd3);
    chk("lit nobyp busy after issue", 32'(bus_n.rd_busy), 32'd3);
    chk("lit pend r9", bus_b.pend, 32'h0000_0200);
    cyc(); rd(9, 9);
    @(negedge clk);
    chk("lit busy held", 32'(bus_b.rd_busy), 32'd3);
    cyc(); wr(0, 9, 32'h1234_5678); rd(9, 9);
    @(negedge clk);
    chk("lit byp busy write cycle", 32'(bus_b.rd_busy), 32'd0);
    chk("lit nobyp busy write cycle", 32'(bus_n.rd_busy), 32'd3);
    chk("lit byp r9 forwarded", bus_b.rd_data[31:0], 32'h1234_5678);
    cyc(); rd(9, 9);
    @(negedge clk);
    chk("lit pend r9 retired", bus_b.pend, 32'h0);
    chk("lit nobyp busy retired", 32'(bus_n.rd_busy), 32'd0);
    chk("lit nobyp r9 stored", bus_n.rd_data[31:0], 32'h1234_5678);

    // Issue and write the same register together: set wins
    cyc(); iss(9); wr(1, 9, 32'h55); rd(9, 9);
    @(negedge clk);
    chk("lit byp r9 set+clr cycle", bus_b.rd_data[31:0], 32'h55);
    cyc(); rd(9, 9);
    @(negedge clk);
    chk("lit pend set wins", bus_b.pend, 32'h0000_0200);
    chk("lit r9 data after set+clr", bus_n.rd_data[31:0], 32'h55);
    chk("lit busy set wins", 32'(bus_b.rd_busy), 32'd3);

    // Pend r4 and r8, then reset (with a write and issue that must be dropped)
    cyc(); wr(0, 4, 32'hBB); wr(1, 8, 32'hAA); rd(4, 8);
    cyc(); iss(4); rd(4, 8);
    @(negedge clk);
    chk("lit r4 stored", bus_n.rd_data[31:0], 32'hBB);
    chk("lit r8 stored", bus_n.rd_data[63:32], 32'hAA);
    cyc(); iss(8); rd(4, 8);
    @(negedge clk);
    chk("lit pend r4 r9", bus_b.pend, 32'h0000_0210);
    cyc(); reset = 1'b1; wr(0, 4, 32'hFFFF); iss(5); rd(4, 8);
    @(negedge clk);
    chk("lit pend r4 r8 r9", bus_b.pend, 32'h0000_0310);
    cyc(); reset = 1'b0; rd(4, 8);
    @(negedge clk);
    chk("lit pend after reset", bus_b.pend, 32'h0);
    chk("lit r4 after reset", bus_n.rd_data[31:0], 32'h0);
    chk("lit r8 after reset", bus_n.rd_data[63:32], 32'h0);
    chk("lit busy after reset", 32'(bus_b.rd_busy), 32'd0);
    cyc(); rd(29, 31);
    @(negedge clk);
    chk("lit r29 after reset", bus_n.rd_data[31:0], SP);
    chk("lit r31 after reset", bus_n.rd_data[63:32], RA);

    // Random traffic, concentrated on a few registers to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NWR; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
             $urandom);
        end
      end
      if ($urandom_range(0, 2) == 0) iss(int'($urandom_range(0, 7)));
      rd(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                                 : int'($urandom_range(0, 7)));
    end

    cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with write-to-read bypass and a per-register scoreboard, for the full pipelined processor. It replaces the fixed 2-read/1-write file in the decode stage. It serves NRD read ports and NWR write-back ports. It tracks which registers have an in-flight producer, so decode can stall on RAW hazards without a separate hazard table.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; r0 hard-wired to zero
- NRD, 2, number of read ports
- NWR, 1, number of write ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see old value
- SP_INIT, 0, reset value of r29
- RA_INIT, 0, reset value of r31
- AW, derived, $clog2(NREGS)
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  NWR  per-port write enable
- wr_num  in  NWR*AW  per-port destination register, port i in bits [i*AW +: AW]
- wr_data  in  NWR*DATA_W  per-port write data
- rd_num  in  NRD*AW  per-port source register
- rd_data  out  NRD*DATA_W  per-port read data
- rd_busy  out  NRD  1 = source register has a pending producer
- iss_en  in  1  decode issues an instruction that writes a register
- iss_num  in  AW  destination of issued instruction
- pend  out  NREGS  scoreboard vector, bit 0 always 0

## Operation
- Storage: r1..r(NREGS-1), DATA_W each. r0 is never stored, always reads 0, never pending.
- Reset, at a clock edge with reset=1:
  - r29 ← SP_INIT, r31 ← RA_INIT, all other registers ← 0, pend ← 0.
  - Writes and issues in that cycle are ignored.
- Write: wr_en[i] && wr_num[i]!=0 → register updated at posedge.
  - Same register from several ports in one cycle: highest port index wins.
- Read (combinational): rd_data[j] = 0 if rd_num[j]==0.
  - Otherwise, with BYPASS=1 and a matching enabled write port this cycle: that port's wr_data (highest index wins).
  - Otherwise: the stored value.
- Scoreboard, updated at posedge:
  - An enabled write on port i clears pend[wr_num[i]].
  - iss_en && iss_num!=0 sets pend[iss_num].
  - Set and clear of the same register in one cycle: set wins, because a new producer supersedes the one retiring.
- rd_busy[j]:
  - BYPASS=1: pend[rd_num[j]] && no enabled write to rd_num[j] this cycle.
  - BYPASS=0: pend[rd_num[j]].
  - Always 0 for rd_num[j]==0.
- Write to a non-pending register is legal: data updates, pend unchanged (stays 0).

## Timing
- Write latency 1 cycle. Read latency 0 (combinational from rd_num, wr_*, and state).
- BYPASS=1: a value written in cycle N is visible on rd_data in cycle N. BYPASS=0: visible in N+1.
- Issue in cycle N → pend and rd_busy asserted from cycle N+1.
- Reset mid-operation: all in-flight pending state is discarded. Outputs after the reset edge:
  - rd_data = 0, except r29/r31, which read their init values.
  - rd_busy = 0, pend = 0.
- No back-pressure: every write and issue is accepted in its cycle.

## Structure
- Shared package rf_pkg: register index constants (REG_ZERO=0, REG_SP=29, REG_RA=31), default DATA_W/NREGS.
- One sub-module, rf_scoreboard: pending-bit vector with set/clear priority and per-port busy lookup.
- Storage and bypass muxing live in regfile_sb.

## Test plan
- Reset with SP_INIT=32'h7FFF_FFFC, RA_INIT=32'h0040_0000 → rd r29=7FFFFFFC, r31=00400000, r5=0; pend=0.
- Write r7=32'hDEAD_BEEF on port 0, read r7 same cycle → BYPASS=1: DEADBEEF in that cycle. BYPASS=0: old value, then DEADBEEF next cycle.
- NWR=2: port0 r3=1 and port1 r3=2 in the same cycle → r3 reads 2 afterward. Write r0=5 → r0 reads 0, pend[0]=0.
- Issue r9 in cycle 1 → rd_busy=1 on r9 from cycle 2. Write r9 in cycle 4 → rd_busy=0 in cycle 4 (BYPASS=1), pend[9]=0 in cycle 5.
- Issue r9 and write r9 in the same cycle → pend[9]=1 next cycle, and r9 holds the written data.
- Pend r4 and r8, assert reset for 1 cycle → pend=0, r4=r8=0, r29/r31 at their init values.
